sar_search: RTL
===============

# sar_search

Sequential successive-approximation controller that drives the trial operand of an external `comparator` instance and recovers an unknown operand from the comparator's `gt`/`lt`/`eq` flags. The comparator is wired with `a` = unknown value and `b` = `trial`. This block resolves one bit per cycle, MSB first, and stops early on `eq`. It handles unsigned and two's-complement operands with the same parameterisation as the comparator, and flags comparator responses that are not one-hot.

## Interface
- `IP_WIDTH`, 8, operand width in bits; must be ≥ 2.
- `IS_SIGNED`, 0, 1 = operands are two's complement; must match the paired comparator.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a new search; accepted only in IDLE or DONE.
- `trial` output IP_WIDTH: registered operand driven to comparator `b`.
- `cmp_gt` input 1: comparator `gt` (unknown > trial).
- `cmp_lt` input 1: comparator `lt` (unknown < trial).
- `cmp_eq` input 1: comparator `eq` (unknown == trial).
- `busy` output 1: high in PROBE.
- `done` output 1: high in DONE; held until next accepted `start` or reset.
- `result` output IP_WIDTH: recovered value; valid while `done`=1.
- `err` output 1: search aborted on a non-one-hot comparator response; valid while `done`=1.
- `probes` output $clog2(IP_WIDTH+1): number of comparator samples taken in the last search.

## Operation
- States:
  - IDLE: after reset.
  - PROBE: searching.
  - DONE: result held.
- Internal search works in offset form: `u = ext ^ (IS_SIGNED << (IP_WIDTH-1))`. `trial` and `result` are always presented in external form.
- Registers:
  - `acc` holds resolved bits, in internal form.
  - `idx` is the current bit index.
  - `probes` counts samples.
- Start: in IDLE or DONE, `start`=1 at an edge does the following:
  - clears `acc`, `err` and `probes`;
  - sets `idx` = IP_WIDTH-1;
  - sets `trial` = ext(1<<(IP_WIDTH-1)), which is 0x80 unsigned or 0x00 signed for width 8;
  - clears `done` and moves to PROBE.
- `start` during PROBE is ignored.
- PROBE, at each edge the block samples `cmp_*` and increments `probes`. Let `t = acc | (1<<idx)`.
  - Response not exactly one of gt/lt/eq asserted: `err`=1, `result`=ext(acc), go to DONE.
  - `cmp_eq`: `result`=`trial`, go to DONE (early termination).
  - `cmp_gt`: `acc`=t.
  - `cmp_lt`: `acc` unchanged.
  - After gt or lt with `idx`=0: `result`=ext(new acc), go to DONE.
  - After gt or lt otherwise: decrement `idx`, `trial`=ext(new acc | (1<<(idx-1))).
- Without error, `result` always equals the unknown value exactly.
- `trial` holds its last probed value in DONE.
- Reset mid-search: the asynchronous abort returns to IDLE immediately with all outputs at their reset values.
- Reset values: state IDLE, `trial`=0, `result`=0, `busy`=0, `done`=0, `err`=0, `probes`=0.

## Timing
- The comparator is combinational, so its response to `trial` is sampled at the next rising edge: one probe per cycle.
- Latency for unsigned operands, counted from the start edge E0 to `done`: k = IP_WIDTH - tz(u) cycles, where tz is the trailing-zero count of u and u=0 gives IP_WIDTH.
- Signed operands use the same rule with u taken in offset form.
- Minimum latency is 1 cycle; maximum is IP_WIDTH.
- `done` rises after edge E_k, together with `result`/`err`/`probes`; `busy` falls on the same edge.
- Back-to-back: `start` held high in DONE begins a new search at the next edge, giving one cycle of `done` between searches.
- The unknown must be stable from E0 to E_k. A change mid-search is not detected, and `result` is then undefined unless `err` fires.

## Test plan
- IP_WIDTH=8, unsigned, unknown 0x5A, start pulse:
  - trial sequence 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A;
  - `done` 7 cycles after the start edge, `result`=0x5A, `probes`=7, `err`=0.
- Unsigned boundaries:
  - unknown 0x00 -> 8 probes, all lt, `result`=0x00;
  - unknown 0xFF -> 8 probes, final eq, `result`=0xFF;
  - unknown 0x80 -> 1 probe, `result`=0x80.
- IS_SIGNED=1:
  - unknown 0xFF (-1) -> first trial 0x00 gives lt, then 0xC0 gt, ... `result`=0xFF, 8 probes;
  - unknown 0x80 (-128) -> `result`=0x80, 8 probes;
  - unknown 0x00 -> 1 probe.
- Protocol error: force gt and lt both high on the 3rd probe -> `done`=1, `err`=1, `probes`=3, `result`=ext(acc at that point).
- Control:
  - `start` pulsed during PROBE -> ignored and the search completes unchanged;
  - `start` held high across DONE -> back-to-back searches with a one-cycle `done` between them.
- Reset: assert `rst` asynchronously at mid-cycle probe 4 -> outputs go to reset values immediately and state is IDLE; the next `start` runs a full correct search.

Source files
------------

// File: rtl/sar_search.sv
// -----------------------------------------------------------------------------
// sar_search
// Successive-approximation controller. It drives the trial operand of an
// external combinational comparator (a = unknown, b = trial) and recovers the
// unknown operand from the comparator's gt/lt/eq flags. It resolves one bit per
// cycle, MSB first, and stops early on eq. The search runs internally in
// offset form, so signed operands reuse the unsigned bit-walk unchanged.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-high reset
//   start   in   request a new search; accepted only in IDLE or DONE
//   trial   out  registered operand for comparator b (external form)
//   cmp_gt  in   comparator gt (unknown > trial)
//   cmp_lt  in   comparator lt (unknown < trial)
//   cmp_eq  in   comparator eq (unknown == trial)
//   busy    out  high while probing
//   done    out  high in DONE until the next accepted start
//   result  out  recovered value (external form), valid while done
//   err     out  search aborted on a non-one-hot comparator response
//   probes  out  number of comparator samples taken in the last search
// -----------------------------------------------------------------------------
module sar_search #(
  parameter int IP_WIDTH  = 8,
  parameter bit IS_SIGNED = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic [IP_WIDTH-1:0]           trial,
  input  logic                          cmp_gt,
  input  logic                          cmp_lt,
  input  logic                          cmp_eq,
  output logic                          busy,
  output logic                          done,
  output logic [IP_WIDTH-1:0]           result,
  output logic                          err,
  output logic [$clog2(IP_WIDTH+1)-1:0] probes
);

  localparam int IW = $clog2(IP_WIDTH);
  localparam int PW = $clog2(IP_WIDTH+1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PROBE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [IP_WIDTH-1:0] ONE       = {{(IP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IP_WIDTH-1:0] MSB_BIT   = {1'b1, {(IP_WIDTH-1){1'b0}}};
  // Flipping the MSB maps two's complement onto an order-preserving unsigned
  // (offset) code; for unsigned operands the mapping is the identity.
  localparam logic [IP_WIDTH-1:0] SIGN_MASK = {IS_SIGNED, {(IP_WIDTH-1){1'b0}}};
  localparam logic [IW-1:0]       IDX_TOP   = IW'(IP_WIDTH-1);
  localparam logic [IW-1:0]       IDX_ONE   = IW'(1);
  localparam logic [IW-1:0]       IDX_ZERO  = IW'(0);
  localparam logic [PW-1:0]       PROBE_ONE = PW'(1);

  // Internal (offset) form to external form; the mapping is its own inverse.
  function automatic logic [IP_WIDTH-1:0] to_ext(input logic [IP_WIDTH-1:0] v);
    return v ^ SIGN_MASK;
  endfunction

  logic [1:0]          state_r;
  logic [IP_WIDTH-1:0] acc_r;
  logic [IW-1:0]       idx_r;

  logic [1:0]          resp_sum_s;
  logic                one_hot_s;
  logic                last_s;
  logic [IP_WIDTH-1:0] new_acc_s;
  logic [IP_WIDTH-1:0] next_trial_s;

  // Decode the comparator response and form the next accumulator and trial.
  always_comb begin
    resp_sum_s = {1'b0, cmp_gt} + {1'b0, cmp_lt} + {1'b0, cmp_eq};
    one_hot_s  = (resp_sum_s == 2'd1);
    last_s     = (idx_r == IDX_ZERO);
    if (cmp_gt) begin
      new_acc_s = acc_r | (ONE << idx_r);
    end else begin
      new_acc_s = acc_r;
    end
    // Only consumed when idx_r > 0, so the wrap at idx_r == 0 is harmless.
    next_trial_s = to_ext(new_acc_s | (ONE << (idx_r - IDX_ONE)));
  end

  // Search FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      acc_r   <= '0;
      idx_r   <= '0;
      trial   <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      probes  <= '0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            acc_r   <= '0;
            err     <= 1'b0;
            probes  <= '0;
            idx_r   <= IDX_TOP;
            trial   <= to_ext(MSB_BIT);
            done    <= 1'b0;
            busy    <= 1'b1;
            state_r <= S_PROBE;
          end else begin
            state_r <= state_r;
          end
        end
        S_PROBE: begin
          probes <= probes + PROBE_ONE;
          if (!one_hot_s) begin
            // Illegal response: report what had been resolved so far.
            err     <= 1'b1;
            result  <= to_ext(acc_r);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= S_DONE;
          end else if (cmp_eq) begin
            result  <= trial;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= S_DONE;
          end else begin
            acc_r <= new_acc_s;
            if (last_s) begin
              result  <= to_ext(new_acc_s);
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= S_DONE;
            end else begin
              idx_r <= idx_r - IDX_ONE;
              trial <= next_trial_s;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
